// File: rtl/timing_pkg.sv
// timing_pkg: shared state encoding, default sizing and tree-entry layout for the timing peak detector
package timing_pkg;
    localparam int DEF_PHASES = 64;
    localparam int DEF_MAG_W  = 32;
    localparam int DEF_CNT_W  = 16;
    localparam int PH_W       = $clog2(DEF_PHASES);
    localparam int IDX_W      = DEF_CNT_W + PH_W;

    typedef enum logic [1:0] {IDLE, SEARCH, TRACK, DONE} state_e;

    typedef struct packed {
        logic [DEF_MAG_W-1:0] mag;
        logic [PH_W-1:0]      phase;
        logic [DEF_CNT_W-1:0] word;
        logic                 gen;
        logic                 valid;
    } entry_t;
endpackage

// File: rtl/timing_peak_detect_phase_argmax.sv
// phase_argmax: pipelined argmax over PHASES lanes, one register stage per tree level.
// Heap-ordered nodes keep lower phases in the left child, so ties resolve to the lower phase.
module phase_argmax
    import timing_pkg::*;
#(
    parameter int PHASES = DEF_PHASES,
    parameter int MAG_W  = DEF_MAG_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [MAG_W*PHASES-1:0]   corr,
    input  logic [CNT_W-1:0]          word,
    input  logic                      gen,
    input  logic                      valid,
    output logic [MAG_W-1:0]          res_mag,
    output logic [$clog2(PHASES)-1:0] res_phase,
    output logic [CNT_W-1:0]          res_word,
    output logic                      res_gen,
    output logic                      res_valid
);
    localparam int PW = $clog2(PHASES);

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic [PW-1:0]    phase;
        logic [CNT_W-1:0] word;
        logic             gen;
        logic             valid;
    } node_t;

    node_t leaf [PHASES];
    node_t node [1:PHASES-1];

    for (genvar p = 0; p < PHASES; p++) begin : g_leaf
        assign leaf[p] = {corr[p*MAG_W +: MAG_W], PW'(p), word, gen, valid};
    end

    for (genvar i = 1; i < PHASES; i++) begin : g_node
        node_t a, b;
        if (2 * i >= PHASES) begin : g_from_leaf
            assign a = leaf[2*i-PHASES];
            assign b = leaf[2*i+1-PHASES];
        end else begin : g_from_node
            assign a = node[2*i];
            assign b = node[2*i+1];
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) node[i] <= '0;
            else node[i] <= (b.mag > a.mag) ? b : a;
        end
    end

    assign res_mag   = node[1].mag;
    assign res_phase = node[1].phase;
    assign res_word  = node[1].word;
    assign res_gen   = node[1].gen;
    assign res_valid = node[1].valid;
endmodule

// File: rtl/timing_peak_detect.sv
// timing_peak_detect: finds the LTF correlation peak after a threshold crossing and
// reports its absolute sample index (word*PHASES+phase) as a locked timing estimate.
module timing_peak_detect
    import timing_pkg::*;
#(
    parameter int PHASES        = DEF_PHASES,
    parameter int MAG_W         = DEF_MAG_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int HOLD_WORDS    = 4,
    parameter int TIMEOUT_WORDS = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [MAG_W*PHASES-1:0]         corr_i,
    input  logic                            corr_valid_i,
    input  logic [MAG_W-1:0]                threshold_i,
    input  logic                            arm_i,
    output logic                            busy_o,
    output logic                            lock_o,
    output logic                            timeout_o,
    output logic [CNT_W+$clog2(PHASES)-1:0] peak_idx_o,
    output logic [MAG_W-1:0]                peak_mag_o
);
    localparam int PW = $clog2(PHASES);
    localparam int IW = CNT_W + PW;
    localparam int HW = $clog2(HOLD_WORDS + 1);

    state_e                    state, state_d;
    logic [CNT_W-1:0]          cnt, word_q, res_word;
    logic                      gen, gen_q, valid_q, res_gen, res_valid, res_ok, timeout_d, busy;
    logic [MAG_W*PHASES-1:0]   corr_q;
    logic [MAG_W-1:0]          res_mag, rec_mag, rec_mag_d;
    logic [PW-1:0]             res_phase;
    logic [IW-1:0]             res_idx, rec_idx, rec_idx_d;
    logic [HW-1:0]             hold, hold_d;

    phase_argmax #(.PHASES(PHASES), .MAG_W(MAG_W), .CNT_W(CNT_W)) u_argmax (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .corr      (corr_q),
        .word      (word_q),
        .gen       (gen_q),
        .valid     (valid_q),
        .res_mag   (res_mag),
        .res_phase (res_phase),
        .res_word  (res_word),
        .res_gen   (res_gen),
        .res_valid (res_valid)
    );

    // A generation mismatch marks words that entered the tree before the latest arm
    assign res_ok  = res_valid && (res_gen == gen);
    assign res_idx = {res_word, res_phase};
    assign busy    = (state == SEARCH) || (state == TRACK);

    always_comb begin
        state_d   = state;
        hold_d    = hold;
        rec_mag_d = rec_mag;
        rec_idx_d = rec_idx;
        timeout_d = 1'b0;
        case (state)
            SEARCH: begin
                if (res_ok && res_mag > threshold_i) begin
                    state_d   = TRACK;
                    hold_d    = HW'(HOLD_WORDS);
                    rec_mag_d = res_mag;
                    rec_idx_d = res_idx;
                end else if (cnt == CNT_W'(TIMEOUT_WORDS)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            TRACK: begin
                if (res_ok) begin
                    if (res_mag > rec_mag) begin
                        rec_mag_d = res_mag;
                        rec_idx_d = res_idx;
                    end
                    hold_d = hold - 1'b1;
                    if (hold == HW'(1)) state_d = DONE;
                end
            end
            default: ;
        endcase
        if (arm_i) begin
            state_d   = SEARCH;
            hold_d    = '0;
            rec_mag_d = '0;
            rec_idx_d = '0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            gen        <= 1'b0;
            corr_q     <= '0;
            valid_q    <= 1'b0;
            word_q     <= '0;
            gen_q      <= 1'b0;
            hold       <= '0;
            rec_mag    <= '0;
            rec_idx    <= '0;
            busy_o     <= 1'b0;
            lock_o     <= 1'b0;
            timeout_o  <= 1'b0;
            peak_idx_o <= '0;
            peak_mag_o <= '0;
        end else begin
            state     <= state_d;
            hold      <= hold_d;
            rec_mag   <= rec_mag_d;
            rec_idx   <= rec_idx_d;
            gen       <= gen ^ arm_i;
            cnt       <= arm_i ? '0 : (busy && corr_valid_i && cnt != '1) ? cnt + 1'b1 : cnt;
            corr_q    <= corr_i;
            valid_q   <= corr_valid_i;
            word_q    <= cnt;
            gen_q     <= gen;
            busy_o    <= (state_d == SEARCH) || (state_d == TRACK);
            lock_o    <= (state == DONE) && !arm_i;
            timeout_o <= timeout_d;
            if (state != DONE && state_d == DONE) begin
                peak_idx_o <= rec_idx_d;
                peak_mag_o <= rec_mag_d;
            end
        end
    end
endmodule
